// File: rtl/fpu_mult_pipe_if.sv
// fpu_mult_pipe_if -- operand/result bus of the pipelined floating-point multiplier.
//
// Handshake: a beat moves across a channel on a rising CLK edge where that
// channel's valid and ready are both high. A source holds valid and its payload
// stable until the beat is taken. A sink may raise or lower ready at any time.
//   input channel : in_valid / in_ready, payload float1, float2, rnd_mode
//   output channel: out_valid / out_ready, payload product, flags
//
// Modports:
//   master -- operand producer / result consumer (drives in_*, out_ready)
//   slave  -- the multiplier (drives in_ready, out_valid, product, flags)
interface fpu_mult_pipe_if #(
  parameter int EXP_W  = 5,
  parameter int FRAC_W = 10
) ();
  localparam int FLOAT_W = 1 + EXP_W + FRAC_W;

  logic               in_valid;
  logic               in_ready;
  logic [FLOAT_W-1:0] float1;
  logic [FLOAT_W-1:0] float2;
  logic               rnd_mode;   // 0 = round-nearest-even, 1 = round-toward-zero
  logic               out_valid;
  logic               out_ready;
  logic [FLOAT_W-1:0] product;
  logic [3:0]         flags;      // {invalid, overflow, underflow, inexact}

  modport master (
    output in_valid, float1, float2, rnd_mode, out_ready,
    input  in_ready, out_valid, product, flags
  );

  modport slave (
    input  in_valid, float1, float2, rnd_mode, out_ready,
    output in_ready, out_valid, product, flags
  );
endinterface

// File: rtl/fpu_mult_pipe.sv
// fpu_mult_pipe -- three-stage pipelined IEEE-style floating-point multiplier.
//   S1: unpack, classify specials, normalize subnormal operands, add exponents
//   S2: significand multiply
//   S3: normalize, round (RNE or RTZ), handle overflow/underflow, pack
// Each stage holds one operation and a valid bit. A stage loads whenever it is
// empty or its contents leave that cycle, so bubbles collapse and stalls ripple
// back combinationally from out_ready to in_ready.
//
// Ports:
//   CLK  -- clock, all state on rising edge
//   RST  -- asynchronous active-high reset, clears every stage
//   bus  -- fpu_mult_pipe_if.slave: operands in, product/flags out
module fpu_mult_pipe #(
  parameter int EXP_W  = 5,
  parameter int FRAC_W = 10
) (
  input logic            CLK,
  input logic            RST,
  fpu_mult_pipe_if.slave bus
);
  localparam int FLOAT_W = 1 + EXP_W + FRAC_W;
  localparam int SIG_W   = FRAC_W + 1;
  localparam int PROD_W  = 2 * SIG_W;
  localparam int EW      = EXP_W + 2;   // signed exponent width, wide enough not to wrap
  localparam int BIAS    = (1 << (EXP_W - 1)) - 1;

  localparam logic [EXP_W-1:0]    EXP_ONES = '1;
  localparam logic signed [EW-1:0] BIAS_S  = EW'(BIAS);
  localparam logic signed [EW-1:0] ONE_S   = EW'(1);
  localparam logic signed [EW-1:0] EMAX_S  = EW'((1 << EXP_W) - 1);
  localparam logic signed [EW-1:0] SH_LIM  = EW'(FRAC_W + 2);

  localparam logic [1:0] CLS_NUM  = 2'd0;
  localparam logic [1:0] CLS_NAN  = 2'd1;
  localparam logic [1:0] CLS_INF  = 2'd2;
  localparam logic [1:0] CLS_ZERO = 2'd3;

  typedef struct packed {
    logic                  is_zero;
    logic                  is_inf;
    logic                  is_nan;
    logic                  is_snan;
    logic [SIG_W-1:0]      sig;    // leading one at MSB for any finite nonzero value
    logic signed [EW-1:0]  uexp;   // unbiased exponent of sig's MSB
  } op_t;

  // Subnormals are shifted left until the leading one reaches the hidden-bit
  // position; the exponent drops by the same amount below the minimum normal.
  function automatic op_t unpack(input logic [FLOAT_W-1:0] f);
    op_t              o;
    logic [EXP_W-1:0] e;
    logic [FRAC_W-1:0] m;
    logic [SIG_W-1:0] s;
    int               lz;
    logic             found;
    e     = f[FLOAT_W-2 -: EXP_W];
    m     = f[FRAC_W-1:0];
    lz    = 0;
    found = 1'b0;
    o.is_zero = (e == '0) && (m == '0);
    o.is_inf  = (e == EXP_ONES) && (m == '0);
    o.is_nan  = (e == EXP_ONES) && (m != '0);
    o.is_snan = o.is_nan && !m[FRAC_W-1];
    if (e == '0) begin
      s = {1'b0, m};
      for (int i = SIG_W - 1; i >= 0; i--) begin
        if (!found) begin
          if (s[i]) found = 1'b1;
          else      lz    = lz + 1;
        end
      end
      o.sig  = s << lz;
      o.uexp = ONE_S - BIAS_S - EW'(lz);
    end else begin
      o.sig  = {1'b1, m};
      o.uexp = $signed({2'b00, e}) - BIAS_S;
    end
    return o;
  endfunction

  // Stage registers
  logic                 r1_v, r1_sign, r1_inv, r1_rnd;
  logic [1:0]           r1_cls;
  logic signed [EW-1:0] r1_exp;
  logic [SIG_W-1:0]     r1_siga, r1_sigb;
  logic                 r2_v, r2_sign, r2_inv, r2_rnd;
  logic [1:0]           r2_cls;
  logic signed [EW-1:0] r2_exp;
  logic [PROD_W-1:0]    r2_prod;
  logic                 r_out_v;
  logic [FLOAT_W-1:0]   r_product;
  logic [3:0]           r_flags;

  logic w_adv1, w_adv2, w_adv3;
  assign w_adv3 = ~r_out_v | bus.out_ready;
  assign w_adv2 = ~r2_v | w_adv3;
  assign w_adv1 = ~r1_v | w_adv2;

  assign bus.in_ready  = w_adv1;
  assign bus.out_valid = r_out_v;
  assign bus.product   = r_product;
  assign bus.flags     = r_flags;

  // S1 classification
  op_t        w_a, w_b;
  logic       w_zero_inf;
  logic [1:0] w_cls;
  logic       w_inv;
  assign w_a        = unpack(bus.float1);
  assign w_b        = unpack(bus.float2);
  assign w_zero_inf = (w_a.is_zero & w_b.is_inf) | (w_a.is_inf & w_b.is_zero);
  assign w_inv      = w_a.is_snan | w_b.is_snan | w_zero_inf;

  always_comb begin
    w_cls = CLS_NUM;
    if (w_a.is_nan | w_b.is_nan | w_zero_inf) w_cls = CLS_NAN;
    else if (w_a.is_inf | w_b.is_inf)         w_cls = CLS_INF;
    else if (w_a.is_zero | w_b.is_zero)       w_cls = CLS_ZERO;
  end

  // S3 normalize / round / pack
  logic                 w_carry, w_tiny, w_g, w_s, w_inc, w_inexact, w_ovf;
  logic [PROD_W-1:0]    w_nm, w_shifted;
  logic signed [EW-1:0] w_be, w_sh, w_bef;
  logic [SIG_W-1:0]     w_keep;
  logic [SIG_W:0]       w_rounded;
  logic [EXP_W-1:0]     w_exp_field;
  logic [FLOAT_W-1:0]   w_pack;
  logic [3:0]           w_fl;

  always_comb begin
    // Product of two [1,2) significands lies in [1,4); put its leading one at the MSB.
    w_carry = r2_prod[PROD_W-1];
    w_nm    = w_carry ? r2_prod : (r2_prod << 1);
    w_be    = r2_exp + BIAS_S + $signed({{(EW-1){1'b0}}, w_carry});
    w_tiny  = (w_be < ONE_S);
    // Tiny results are denormalized so the stored exponent field becomes zero.
    w_sh    = w_tiny ? (ONE_S - w_be) : '0;
    w_shifted = '0;
    if (w_sh > SH_LIM) begin
      w_keep = '0;
      w_g    = 1'b0;
      w_s    = 1'b1;
    end else begin
      w_shifted = w_nm >> w_sh;
      w_keep    = w_shifted[PROD_W-1 -: SIG_W];
      w_g       = w_shifted[PROD_W-1-SIG_W];
      w_s       = (|w_shifted[PROD_W-2-SIG_W:0]) | (|(w_nm & ~({PROD_W{1'b1}} << w_sh)));
    end
    w_inc      = ~r2_rnd & w_g & (w_s | w_keep[0]);
    w_rounded  = {1'b0, w_keep} + {{SIG_W{1'b0}}, w_inc};
    w_inexact  = w_g | w_s;
    // A carry out of rounding turns 1.11..1 into 10.00..0: fraction bits are
    // already zero, only the exponent moves up.
    w_bef      = w_be + $signed({{(EW-1){1'b0}}, w_rounded[SIG_W]});
    w_ovf      = ~w_tiny & (w_bef >= EMAX_S);
    // A subnormal that rounds into the hidden-bit position becomes min normal.
    w_exp_field = w_tiny ? {{(EXP_W-1){1'b0}}, w_rounded[SIG_W-1]} : w_bef[EXP_W-1:0];

    w_pack = '0;
    w_fl   = 4'b0000;
    case (r2_cls)
      CLS_NAN: begin
        w_pack = '1;
        w_fl   = {r2_inv, 3'b000};
      end
      CLS_INF:  w_pack = {r2_sign, EXP_ONES, {FRAC_W{1'b0}}};
      CLS_ZERO: w_pack = {r2_sign, {(FLOAT_W-1){1'b0}}};
      default: begin
        if (w_ovf) begin
          w_pack = r2_rnd ? {r2_sign, EXP_ONES - 1'b1, {FRAC_W{1'b1}}}
                          : {r2_sign, EXP_ONES, {FRAC_W{1'b0}}};
          w_fl   = 4'b0101;
        end else begin
          w_pack = {r2_sign, w_exp_field, w_rounded[FRAC_W-1:0]};
          w_fl   = {2'b00, w_tiny & w_inexact, w_inexact};
        end
      end
    endcase
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      r1_v      <= 1'b0;
      r1_sign   <= 1'b0;
      r1_inv    <= 1'b0;
      r1_rnd    <= 1'b0;
      r1_cls    <= CLS_NUM;
      r1_exp    <= '0;
      r1_siga   <= '0;
      r1_sigb   <= '0;
      r2_v      <= 1'b0;
      r2_sign   <= 1'b0;
      r2_inv    <= 1'b0;
      r2_rnd    <= 1'b0;
      r2_cls    <= CLS_NUM;
      r2_exp    <= '0;
      r2_prod   <= '0;
      r_out_v   <= 1'b0;
      r_product <= '0;
      r_flags   <= '0;
    end else begin
      if (w_adv1) begin
        r1_v    <= bus.in_valid;
        r1_sign <= bus.float1[FLOAT_W-1] ^ bus.float2[FLOAT_W-1];
        r1_inv  <= w_inv;
        r1_rnd  <= bus.rnd_mode;
        r1_cls  <= w_cls;
        r1_exp  <= w_a.uexp + w_b.uexp;
        r1_siga <= w_a.sig;
        r1_sigb <= w_b.sig;
      end
      if (w_adv2) begin
        r2_v    <= r1_v;
        r2_sign <= r1_sign;
        r2_inv  <= r1_inv;
        r2_rnd  <= r1_rnd;
        r2_cls  <= r1_cls;
        r2_exp  <= r1_exp;
        r2_prod <= PROD_W'(r1_siga) * PROD_W'(r1_sigb);
      end
      if (w_adv3) begin
        r_out_v   <= r2_v;
        r_product <= w_pack;
        r_flags   <= w_fl;
      end
    end
  end
endmodule

// File: tb/tb_fpu_mult_pipe.sv
// Bench for fpu_mult_pipe at binary16. The reference model evaluates each
// product exactly as an integer times a power of two and rounds it to the
// binary16 grid; directed vectors carry hand-derived results as well.
module tb_fpu_mult_pipe;
  // ---------------- clock / reset ----------------
  logic CLK = 1'b0;
  logic RST;
  always #5 CLK = ~CLK;

  fpu_mult_pipe_if #(.EXP_W(5), .FRAC_W(10)) bus ();
  fpu_mult_pipe #(.EXP_W(5), .FRAC_W(10)) dut (.CLK(CLK), .RST(RST), .bus(bus));

  int checks   = 0;
  int failures = 0;
  int n_out    = 0;
  logic [19:0] exp_q[$];   // {flags, product}

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s: got %h, required %h", name, act, req);
    end
  endtask

  // ---------------- reference model ----------------
  function automatic logic [19:0] model(input logic [15:0] a, input logic [15:0] b, input logic rtz);
    logic   sr, a_nan, b_nan, a_inf, b_inf, a_zero, b_zero, zi, inexact, tiny;
    longint ma, mb, p, r, rem, half, one;
    int     xa, xb, x, msb, e, q, sh, bits;
    sr     = a[15] ^ b[15];
    a_nan  = (a[14:10] == 5'h1F) && (a[9:0] != 10'd0);
    b_nan  = (b[14:10] == 5'h1F) && (b[9:0] != 10'd0);
    a_inf  = (a[14:10] == 5'h1F) && (a[9:0] == 10'd0);
    b_inf  = (b[14:10] == 5'h1F) && (b[9:0] == 10'd0);
    a_zero = (a[14:0] == 15'd0);
    b_zero = (b[14:0] == 15'd0);
    zi     = (a_zero && b_inf) || (a_inf && b_zero);
    if (a_nan || b_nan || zi)
      return {(a_nan && !a[9]) || (b_nan && !b[9]) || zi, 3'b000, 16'hFFFF};
    if (a_inf || b_inf) return {4'b0000, sr, 15'h7C00};
    if (a_zero || b_zero) return {4'b0000, sr, 15'h0000};
    // operand value = m * 2^x exactly
    ma = longint'(a[9:0]); if (a[14:10] != 5'd0) ma = ma + 1024;
    mb = longint'(b[9:0]); if (b[14:10] != 5'd0) mb = mb + 1024;
    xa = (a[14:10] == 5'd0) ? -24 : int'(a[14:10]) - 25;
    xb = (b[14:10] == 5'd0) ? -24 : int'(b[14:10]) - 25;
    p = ma * mb;
    x = xa + xb;
    msb = 0;
    for (int i = 0; i < 48; i++) if (p[i]) msb = i;
    e  = x + msb;                        // exponent of the exact product
    q  = (e - 10 > -24) ? e - 10 : -24;  // weight of one result ulp
    sh = q - x;
    one = 1;
    inexact = 1'b0;
    if (sh <= 0) r = p << (-sh);
    else begin
      r    = p >> sh;
      rem  = p & ((one << sh) - 1);
      half = one << (sh - 1);
      inexact = (rem != 0);
      if (!rtz && (rem > half || (rem == half && r[0]))) r = r + 1;
    end
    if (r == 2048) begin r = 1024; q = q + 1; end
    bits = (q + 24) * 1024 + int'(r);
    tiny = (e < -14);
    if (bits >= 31744) return {4'b0101, sr, rtz ? 15'h7BFF : 15'h7C00};
    return {2'b00, tiny && inexact, inexact, sr, bits[14:0]};
  endfunction

  // ---------------- scoreboard / compare process ----------------
  logic        prev_stall = 1'b0;
  logic [19:0] prev_out   = '0;
  logic [19:0] sb_exp;
  always @(negedge CLK) begin
    if (RST) begin
      exp_q.delete();
      prev_stall = 1'b0;
    end else begin
      if (prev_stall)
        check("hold_stable", 32'({bus.out_valid, bus.flags, bus.product}), 32'({1'b1, prev_out}));
      if (bus.out_valid && bus.out_ready) begin
        if (exp_q.size() == 0) begin
          checks++;
          failures++;
          $display("FAIL spurious_out: got product %h flags %b, required no output", bus.product, bus.flags);
        end else begin
          sb_exp = exp_q.pop_front();
          check("sb_product", 32'(bus.product), 32'(sb_exp[15:0]));
          check("sb_flags", 32'(bus.flags), 32'(sb_exp[19:16]));
          n_out++;
        end
      end
      if (bus.in_valid && bus.in_ready)
        exp_q.push_back(model(bus.float1, bus.float2, bus.rnd_mode));
      prev_stall = bus.out_valid && !bus.out_ready;
      prev_out   = {bus.flags, bus.product};
    end
  end

  // ---------------- driver tasks ----------------
  task automatic tick();
    @(posedge CLK);
    #2;
  endtask

  task automatic send(input logic [15:0] a, input logic [15:0] b, input logic rtz);
    logic acc;
    int   guard;
    bus.in_valid = 1'b1;
    bus.float1   = a;
    bus.float2   = b;
    bus.rnd_mode = rtz;
    guard = 0;
    do begin
      #1;
      acc = bus.in_ready;
      tick();
      guard++;
    end while (!acc && guard < 50);
    bus.in_valid = 1'b0;
    if (!acc) begin
      checks++;
      failures++;
      $display("FAIL send_timeout: got in_ready low for %0d cycles, required acceptance", guard);
    end
  endtask

  typedef struct {
    logic [15:0] a;
    logic [15:0] b;
    logic        rtz;
    logic [15:0] p;
    logic [3:0]  f;
  } vec_t;
  vec_t vecs[19];

  logic [15:0] bp_a[5];
  logic [15:0] bp_b[5];

  initial begin : watchdog
    #200000;
    failures++;
    $display("FAIL watchdog: got no end of test, required completion");
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin : main
    int   lat, k, guard, base;
    logic acc;
    vecs[0]  = '{16'h3E00, 16'h3E00, 1'b0, 16'h4080, 4'b0000};
    vecs[1]  = '{16'h7BFF, 16'h4000, 1'b0, 16'h7C00, 4'b0101};
    vecs[2]  = '{16'h7BFF, 16'h4000, 1'b1, 16'h7BFF, 4'b0101};
    vecs[3]  = '{16'h0001, 16'h3800, 1'b0, 16'h0000, 4'b0011};
    vecs[4]  = '{16'h0001, 16'h3C00, 1'b0, 16'h0001, 4'b0000};
    vecs[5]  = '{16'h0000, 16'h7C00, 1'b0, 16'hFFFF, 4'b1000};
    vecs[6]  = '{16'h7D00, 16'h3C00, 1'b0, 16'hFFFF, 4'b1000};
    vecs[7]  = '{16'h8000, 16'h3C00, 1'b0, 16'h8000, 4'b0000};
    vecs[8]  = '{16'h7E00, 16'h3C00, 1'b0, 16'hFFFF, 4'b0000};
    vecs[9]  = '{16'h7C00, 16'hC000, 1'b0, 16'hFC00, 4'b0000};
    vecs[10] = '{16'h0000, 16'h8001, 1'b0, 16'h8000, 4'b0000};
    vecs[11] = '{16'h3C01, 16'h3E00, 1'b0, 16'h3E02, 4'b0001};
    vecs[12] = '{16'h3C01, 16'h3E00, 1'b1, 16'h3E01, 4'b0001};
    vecs[13] = '{16'h3C03, 16'h3E00, 1'b0, 16'h3E04, 4'b0001};
    vecs[14] = '{16'h03FF, 16'h3C01, 1'b0, 16'h0400, 4'b0011};
    vecs[15] = '{16'h03FF, 16'h3C01, 1'b1, 16'h03FF, 4'b0011};
    vecs[16] = '{16'h0200, 16'h0200, 1'b0, 16'h0000, 4'b0011};
    vecs[17] = '{16'hC000, 16'hC000, 1'b0, 16'h4400, 4'b0000};
    vecs[18] = '{16'h7BFF, 16'h3C01, 1'b0, 16'h7C00, 4'b0101};
    bp_a = '{16'h3C00, 16'h4000, 16'h4200, 16'h3800, 16'hBC00};
    bp_b = '{16'h4000, 16'h4000, 16'h4000, 16'h3800, 16'h3C00};

    // pin the model with a few hand-worked results
    check("model_pin_3e00", 32'(model(16'h3E00, 16'h3E00, 1'b0)), 32'h04080);
    check("model_pin_ovf",  32'(model(16'h7BFF, 16'h4000, 1'b1)), 32'h57BFF);
    check("model_pin_sub",  32'(model(16'h0001, 16'h3800, 1'b0)), 32'h30000);
    check("model_pin_tie",  32'(model(16'h3C03, 16'h3E00, 1'b0)), 32'h13E04);

    // reset state
    bus.in_valid = 1'b0; bus.float1 = '0; bus.float2 = '0; bus.rnd_mode = 1'b0;
    bus.out_ready = 1'b1;
    RST = 1'b1;
    tick(); tick();
    check("rst_out_valid", 32'(bus.out_valid), 32'd0);
    check("rst_product", 32'(bus.product), 32'd0);
    check("rst_flags", 32'(bus.flags), 32'd0);
    RST = 1'b0;
    #1;
    check("rst_in_ready", 32'(bus.in_ready), 32'd1);
    tick();

    // directed vectors, one at a time, with latency and hand results
    foreach (vecs[i]) begin
      send(vecs[i].a, vecs[i].b, vecs[i].rtz);
      lat = 1;
      while (!bus.out_valid && lat < 10) begin tick(); lat++; end
      check("latency", 32'(lat), 32'd3);
      check("vec_product", 32'(bus.product), 32'(vecs[i].p));
      check("vec_flags", 32'(bus.flags), 32'(vecs[i].f));
      tick();
    end

    // back-to-back stream of the table, scoreboard only
    foreach (vecs[i]) send(vecs[i].a, vecs[i].b, vecs[i].rtz);
    guard = 0;
    while (exp_q.size() != 0 && guard < 20) begin tick(); guard++; end

    // backpressure: consumer stalls for six cycles
    bus.out_ready = 1'b0;
    k = 0;
    for (int c = 0; c < 6; c++) begin
      bus.in_valid = 1'b1; bus.float1 = bp_a[k]; bus.float2 = bp_b[k]; bus.rnd_mode = 1'b0;
      #1;
      acc = bus.in_ready;
      tick();
      if (acc) k++;
    end
    bus.in_valid = 1'b0;
    #1;
    check("bp_accepted", 32'(k), 32'd3);
    check("bp_in_ready_low", 32'(bus.in_ready), 32'd0);
    check("bp_stall_head", 32'(bus.product), 32'h4000);
    base = n_out;
    bus.out_ready = 1'b1;
    guard = 0;
    while (k < 5 && guard < 50) begin
      bus.in_valid = 1'b1; bus.float1 = bp_a[k]; bus.float2 = bp_b[k];
      #1;
      acc = bus.in_ready;
      tick();
      if (acc) k++;
      guard++;
    end
    bus.in_valid = 1'b0;
    guard = 0;
    while (exp_q.size() != 0 && guard < 20) begin tick(); guard++; end
    check("bp_outputs", 32'(n_out - base), 32'd5);

    // reset with three operations in flight
    bus.out_ready = 1'b0;
    send(16'h4000, 16'h4000, 1'b0);
    send(16'h3E00, 16'h3E00, 1'b0);
    send(16'h3C00, 16'h4200, 1'b0);
    RST = 1'b1;
    #1;
    check("midrst_out_valid", 32'(bus.out_valid), 32'd0);
    tick();
    check("midrst_product", 32'(bus.product), 32'd0);
    check("midrst_flags", 32'(bus.flags), 32'd0);
    RST = 1'b0;
    bus.out_ready = 1'b1;
    for (int c = 0; c < 6; c++) begin
      tick();
      check("postrst_no_stale", 32'(bus.out_valid), 32'd0);
    end

    // pipeline still alive after reset
    send(16'h3E00, 16'h3E00, 1'b0);
    lat = 1;
    while (!bus.out_valid && lat < 10) begin tick(); lat++; end
    check("postrst_product", 32'(bus.product), 32'h4080);
    tick(); tick();
    check("queue_drained", 32'(exp_q.size()), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/fpu_mult_pipe.md
FPU_MULT_PIPE -- requirements
Module: fpu_mult_pipe

Interface
REQ-001 The block SHALL have parameter EXP_W, default 5, the exponent width.
REQ-002 The block SHALL have parameter FRAC_W, default 10, the stored fraction width; FLOAT_W = 1+EXP_W+FRAC_W (default 16, IEEE binary16).
REQ-003 The block SHALL have the ports below, one clock and one reset; reset is asynchronous and active-high:
  CLK  in  1  clock; all state on rising edge
  RST  in  1  asynchronous active-high reset
  in_valid  in  1  operand pair valid
  in_ready  out  1  block can accept operands this cycle
  float1  in  FLOAT_W  operand A
  float2  in  FLOAT_W  operand B
  rnd_mode  in  1  0 = round-nearest-even (RNE), 1 = round-toward-zero (RTZ); sampled with operands
  out_valid  out  1  product valid
  out_ready  in  1  consumer accepts product this cycle
  product  out  FLOAT_W  result
  flags  out  4  {invalid, overflow, underflow, inexact}, aligned with product

Function
REQ-004 Transfer occurs on a cycle where valid and ready are both high; each accepted pair SHALL produce exactly one product, in order.
REQ-005 The datapath SHALL be three registered stages: S1 unpack/classify/subnormal-normalize, S2 significand multiply (2*(FRAC_W+1) bits), S3 normalize/round/pack.
REQ-006 Latency SHALL be 3 cycles from input transfer to out_valid with out_ready held high; throughput one per cycle.
REQ-007 Each stage SHALL load when it is empty or its contents leave that cycle; in_ready = ~S1_full | S1 advancing (combinational on out_ready permitted); bubbles SHALL collapse.
REQ-008 With out_ready low, product, flags and out_valid SHALL hold stable until transfer.
REQ-009 Sign of every non-NaN result SHALL be sign(float1) XOR sign(float2), including zero results.
REQ-010 Any NaN operand, or zero times infinity, SHALL yield canonical qNaN (all bits 1); invalid SHALL be set for sNaN operands (exp all-ones, fraction MSB 0, fraction nonzero) and zero times infinity, clear for qNaN inputs.
REQ-011 Infinity times finite nonzero SHALL yield signed infinity, no flags.
REQ-012 Zero times finite SHALL yield signed zero, no flags.
REQ-013 Subnormal operands SHALL be normalized via leading-one detect before multiply; unbiased exponent arithmetic SHALL use EXP_W+2 signed bits so no intermediate wraps.
REQ-014 Rounding SHALL use guard and sticky over all discarded bits; RNE rounds half to even; RTZ truncates; round carry-out SHALL renormalize and increment exponent.
REQ-015 Result exponent above max finite SHALL set overflow and inexact; result = signed infinity (RNE) or signed max finite (RTZ).
REQ-016 Tiny results (exponent below minimum normal before rounding) SHALL be right-shifted into subnormal form with sticky collected, then rounded; shift amounts beyond FRAC_W+2 SHALL collapse to sticky only.
REQ-017 underflow SHALL be set when the result is tiny and inexact; a subnormal rounding up to min normal SHALL produce min normal with underflow still set.
REQ-018 inexact SHALL be set whenever any discarded bit is nonzero or overflow occurs.

Reset
REQ-019 While RST is high: all stage valid bits, out_valid, product and flags SHALL be 0; in_ready SHALL be 1 the first cycle after RST deasserts.
REQ-020 RST asserted mid-operation SHALL discard all in-flight operations; none SHALL emerge after release.

Verification
REQ-021 0x3E00 x 0x3E00, RNE, out_ready=1 -> 0x4080 at cycle 3, flags 0000.
REQ-022 0x7BFF x 0x4000 -> RNE 0x7C00 flags 0101; RTZ 0x7BFF flags 0101.
REQ-023 0x0001 x 0x3800, RNE -> 0x0000 flags 0011; 0x0001 x 0x3C00 -> 0x0001 flags 0000.
REQ-024 0x0000 x 0x7C00 -> 0xFFFF flags 1000; 0x7D00 x 0x3C00 -> 0xFFFF flags 1000; 0x8000 x 0x3C00 -> 0x8000.
REQ-025 Issue 5 back-to-back pairs with out_ready low 6 cycles -> in_ready drops after 3 accepted; on release all 5 products emerge in order, none lost or duplicated.
REQ-026 RST pulsed with 3 ops in flight -> out_valid 0 during and after reset; no stale product appears.
